// File: rtl/sram_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter_if
// One sram-like (req/addr_ok/data_ok) channel. The requester drives the
// request fields and receives the handshakes and read data.
//
// Signals:
//   req      request valid, held until addr_ok
//   wr       write flag
//   size     0=byte, 1=half, 2=word
//   wstrb    byte strobes
//   addr     byte address
//   wdata    write data
//   addr_ok  request accepted
//   data_ok  response valid (read data or write completion)
//   rdata    read data, meaningful only with data_ok
//
// Modports:
//   master   the requester side
//   slave    the responder side
// -----------------------------------------------------------------------------
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
// Two-master / one-slave arbiter for the sram-like bus. Master 0 is the
// instruction-fetch port, master 1 the load/store port. One transaction is
// outstanding at a time. The data port wins simultaneous requests until it has
// taken MAX_DATA_STREAK grants in a row while fetch was waiting; the next
// conflict then goes to fetch.
//
// Ports:
//   clk    clock
//   reset  synchronous reset, active-high; forces every output to 0
//   inst   master 0 channel (slave modport: arbiter answers the master)
//   data   master 1 channel (slave modport)
//   mem    shared memory channel (master modport: arbiter requests)
//
// Parameters:
//   MAX_DATA_STREAK  consecutive data grants allowed while fetch waits (1..15)
// -----------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_bus_arbiter_if.slave         inst,
    sram_bus_arbiter_if.slave         data,
    sram_bus_arbiter_if.master        mem
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_r;
    logic                  gnt_r;       // 0 = inst owns the bus, 1 = data
    logic [STREAK_W-1:0]   streak_r;
    logic                  mem_req_r;

    logic                  pick_data_s;
    logic                  in_req_s;
    logic                  in_resp_s;
    logic                  mem_req_s;
    logic                  mem_wr_s;
    logic [1:0]            mem_size_s;
    logic [3:0]            mem_wstrb_s;
    logic [31:0]           mem_addr_s;
    logic [31:0]           mem_wdata_s;
    logic                  inst_addr_ok_s;
    logic                  data_addr_ok_s;
    logic                  inst_data_ok_s;
    logic                  data_data_ok_s;
    logic [31:0]           rdata_s;

    // Saturating increment of the data-streak counter.
    function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur);
        if (cur >= STREAK_MAX) begin
            return STREAK_MAX;
        end else begin
            return cur + STREAK_W'(1);
        end
    endfunction

    // Arbitration decision: data wins unless fetch is waiting and the streak is used up.
    always_comb begin
        pick_data_s = 1'b0;
        if (data.req && (!inst.req || (streak_r != STREAK_MAX))) begin
            pick_data_s = 1'b1;
        end else begin
            pick_data_s = 1'b0;
        end
    end

    // Control FSM with owner, streak and registered mem_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 1'b0;
            streak_r  <= {STREAK_W{1'b0}};
            mem_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_data_s) begin
                        gnt_r     <= 1'b1;
                        // The streak only grows while fetch is actually waiting.
                        streak_r  <= inst.req ? streak_inc(streak_r) : {STREAK_W{1'b0}};
                        state_r   <= ST_REQ;
                        mem_req_r <= 1'b1;
                    end else if (inst.req) begin
                        gnt_r     <= 1'b0;
                        streak_r  <= {STREAK_W{1'b0}};
                        state_r   <= ST_REQ;
                        mem_req_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // A master dropping req here is a protocol violation; stay put.
                    if (mem.addr_ok) begin
                        state_r   <= ST_RESP;
                        mem_req_r <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (mem.data_ok) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Output steering; reset overrides everything so an in-flight transaction is cut cleanly.
    always_comb begin
        in_req_s       = 1'b0;
        in_resp_s      = 1'b0;
        mem_req_s      = 1'b0;
        mem_wr_s       = 1'b0;
        mem_size_s     = 2'd0;
        mem_wstrb_s    = 4'd0;
        mem_addr_s     = 32'd0;
        mem_wdata_s    = 32'd0;
        inst_addr_ok_s = 1'b0;
        data_addr_ok_s = 1'b0;
        inst_data_ok_s = 1'b0;
        data_data_ok_s = 1'b0;
        rdata_s        = 32'd0;
        if (!reset) begin
            in_req_s       = mem_req_r;
            in_resp_s      = (state_r == ST_RESP);
            mem_req_s      = mem_req_r;
            mem_wr_s       = gnt_r ? data.wr    : inst.wr;
            mem_size_s     = gnt_r ? data.size  : inst.size;
            mem_wstrb_s    = gnt_r ? data.wstrb : inst.wstrb;
            mem_addr_s     = gnt_r ? data.addr  : inst.addr;
            mem_wdata_s    = gnt_r ? data.wdata : inst.wdata;
            // Slave handshakes are only forwarded in the phase that expects them.
            inst_addr_ok_s = in_req_s  && !gnt_r && mem.addr_ok;
            data_addr_ok_s = in_req_s  &&  gnt_r && mem.addr_ok;
            inst_data_ok_s = in_resp_s && !gnt_r && mem.data_ok;
            data_data_ok_s = in_resp_s &&  gnt_r && mem.data_ok;
            rdata_s        = mem.rdata;
        end else begin
            rdata_s        = 32'd0;
        end
    end

    assign mem.req      = mem_req_s;
    assign mem.wr       = mem_wr_s;
    assign mem.size     = mem_size_s;
    assign mem.wstrb    = mem_wstrb_s;
    assign mem.addr     = mem_addr_s;
    assign mem.wdata    = mem_wdata_s;

    assign inst.addr_ok = inst_addr_ok_s;
    assign inst.data_ok = inst_data_ok_s;
    assign inst.rdata   = rdata_s;
    assign data.addr_ok = data_addr_ok_s;
    assign data.data_ok = data_data_ok_s;
    assign data.rdata   = rdata_s;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Directed scenarios followed by randomized traffic. Random traffic is checked
// against a transaction-level model: bus phase (free / request / response),
// owner, and a count of consecutive data grants made while fetch was waiting.
// -----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int MAX_STREAK = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sram_bus_arbiter_if i_if ();
    sram_bus_arbiter_if d_if ();
    sram_bus_arbiter_if m_if ();

    sram_bus_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (i_if),
        .data  (d_if),
        .mem   (m_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int          m_st [2];      // 0 idle, 1 requesting, 2 awaiting response
    logic        m_wr [2];
    logic [1:0]  m_size [2];
    logic [3:0]  m_wstrb [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    int          phase;         // 0 bus free, 1 request phase, 2 response phase
    int          owner;
    int          streak;
    int          p_start [2];
    int          p_aok;
    int          p_dok;
    int          glog [$];
    int          aok_cnt;
    int          dok_cnt;
    int          iok_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_wr[i] = 1'b0; m_size[i] = 2'd0;
            m_wstrb[i] = 4'd0; m_addr[i] = 32'd0; m_wdata[i] = 32'd0;
        end
        i_if.req = 1'b0; i_if.wr = 1'b0; i_if.size = 2'd0; i_if.wstrb = 4'd0;
        i_if.addr = 32'd0; i_if.wdata = 32'd0;
        d_if.req = 1'b0; d_if.wr = 1'b0; d_if.size = 2'd0; d_if.wstrb = 4'd0;
        d_if.addr = 32'd0; d_if.wdata = 32'd0;
        m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = 32'd0;
    endtask

    task automatic drive_masters();
        i_if.req = (m_st[0] == 1); i_if.wr = m_wr[0]; i_if.size = m_size[0];
        i_if.wstrb = m_wstrb[0]; i_if.addr = m_addr[0]; i_if.wdata = m_wdata[0];
        d_if.req = (m_st[1] == 1); d_if.wr = m_wr[1]; d_if.size = m_size[1];
        d_if.wstrb = m_wstrb[1]; d_if.addr = m_addr[1]; d_if.wdata = m_wdata[1];
    endtask

    // One bus cycle of randomized masters and slave, checked against the model.
    task automatic model_cycle(input string tag);
        logic        s_aok;
        logic        s_dok;
        logic [31:0] rd;
        logic [31:0] r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 0 && int'($urandom_range(99, 0)) < p_start[i]) begin
                m_st[i]    = 1;
                r          = $urandom();
                m_addr[i]  = {(i == 0) ? 4'h1 : 4'h8, r[27:2], 2'b00};
                m_wr[i]    = 1'($urandom_range(1, 0));
                m_size[i]  = 2'($urandom_range(2, 0));
                m_wstrb[i] = 4'($urandom());
                m_wdata[i] = $urandom();
            end
        end
        drive_masters();
        rd = $urandom();
        if (phase == 1) s_aok = (int'($urandom_range(99, 0)) < p_aok);
        else            s_aok = ($urandom_range(7, 0) == 0);
        if (phase == 2) s_dok = (int'($urandom_range(99, 0)) < p_dok);
        else            s_dok = ($urandom_range(7, 0) == 0);
        m_if.addr_ok = s_aok;
        m_if.data_ok = s_dok;
        m_if.rdata   = rd;
        #1;
        chk({tag, "_mem_req"}, m_if.req, (phase == 1));
        if (phase == 1) begin
            chk({tag, "_mem_addr"},  m_if.addr,  m_addr[owner]);
            chk({tag, "_mem_wr"},    m_if.wr,    m_wr[owner]);
            chk({tag, "_mem_size"},  m_if.size,  m_size[owner]);
            chk({tag, "_mem_wstrb"}, m_if.wstrb, m_wstrb[owner]);
            chk({tag, "_mem_wdata"}, m_if.wdata, m_wdata[owner]);
        end
        chk({tag, "_inst_addr_ok"}, i_if.addr_ok, (phase == 1 && owner == 0 && s_aok));
        chk({tag, "_data_addr_ok"}, d_if.addr_ok, (phase == 1 && owner == 1 && s_aok));
        chk({tag, "_inst_data_ok"}, i_if.data_ok, (phase == 2 && owner == 0 && s_dok));
        chk({tag, "_data_data_ok"}, d_if.data_ok, (phase == 2 && owner == 1 && s_dok));
        if (phase == 2 && s_dok) begin
            if (owner == 0) chk({tag, "_inst_rdata"}, i_if.rdata, rd);
            else            chk({tag, "_data_rdata"}, d_if.rdata, rd);
        end
        // advance the model to the next cycle
        if (phase == 0) begin
            if (m_st[0] == 1 || m_st[1] == 1) begin
                if (m_st[1] == 1 && !(m_st[0] == 1 && streak == MAX_STREAK)) begin
                    owner  = 1;
                    streak = (m_st[0] == 1) ? ((streak < MAX_STREAK) ? streak + 1 : MAX_STREAK) : 0;
                end else begin
                    owner  = 0;
                    streak = 0;
                end
                phase = 1;
            end
        end else if (phase == 1) begin
            if (s_aok) begin
                glog.push_back(int'(m_if.addr[31]));
                phase = 2;
                m_st[owner] = 2;
            end
        end else begin
            if (s_dok) begin
                phase = 0;
                m_st[owner] = 0;
            end
        end
    endtask

    initial begin
        // ---------------- reset with dirty inputs ----------------
        clr();
        reset = 1'b1;
        i_if.req = 1'b1; i_if.addr = 32'h1c000000;
        m_if.addr_ok = 1'b1; m_if.data_ok = 1'b1; m_if.rdata = 32'hdeadbeef;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req",      m_if.req,     32'd0);
        chk("rst_mem_addr",     m_if.addr,    32'd0);
        chk("rst_inst_addr_ok", i_if.addr_ok, 32'd0);
        chk("rst_data_addr_ok", d_if.addr_ok, 32'd0);
        chk("rst_inst_data_ok", i_if.data_ok, 32'd0);
        chk("rst_data_data_ok", d_if.data_ok, 32'd0);
        chk("rst_inst_rdata",   i_if.rdata,   32'd0);
        chk("rst_data_rdata",   d_if.rdata,   32'd0);
        @(negedge clk);
        reset = 1'b0;
        clr();

        // ---------------- single inst read ----------------
        @(negedge clk);
        i_if.req = 1'b1; i_if.addr = 32'h1c000000; i_if.size = 2'd2;
        #1;
        chk("t1_c0_mem_req", m_if.req, 32'd0);
        @(negedge clk);
        #1;
        chk("t1_c1_mem_req",  m_if.req,  32'd1);
        chk("t1_c1_mem_addr", m_if.addr, 32'h1c000000);
        chk("t1_c1_mem_wr",   m_if.wr,   32'd0);
        m_if.addr_ok = 1'b1;
        #1;
        chk("t1_c1_inst_addr_ok", i_if.addr_ok, 32'd1);
        chk("t1_c1_data_addr_ok", d_if.addr_ok, 32'd0);
        @(negedge clk);
        i_if.req = 1'b0; m_if.addr_ok = 1'b0;
        #1;
        chk("t1_c2_mem_req",      m_if.req,     32'd0);
        chk("t1_c2_inst_data_ok", i_if.data_ok, 32'd0);
        @(negedge clk);
        m_if.data_ok = 1'b1; m_if.rdata = 32'h02800c0c;
        #1;
        chk("t1_c3_inst_data_ok", i_if.data_ok, 32'd1);
        chk("t1_c3_inst_rdata",   i_if.rdata,   32'h02800c0c);
        chk("t1_c3_data_data_ok", d_if.data_ok, 32'd0);
        @(negedge clk);
        m_if.data_ok = 1'b0;
        #1;
        chk("t1_c4_mem_req", m_if.req, 32'd0);

        // ---------------- simultaneous requests ----------------
        @(negedge clk);
        i_if.req = 1'b1; i_if.wr = 1'b0; i_if.addr = 32'h1c000004; i_if.size = 2'd2;
        d_if.req = 1'b1; d_if.wr = 1'b1; d_if.addr = 32'h1c010004; d_if.size = 2'd2;
        d_if.wstrb = 4'hF; d_if.wdata = 32'h12345678;
        @(negedge clk);
        #1;
        chk("t2_mem_req",   m_if.req,   32'd1);
        chk("t2_mem_wr",    m_if.wr,    32'd1);
        chk("t2_mem_addr",  m_if.addr,  32'h1c010004);
        chk("t2_mem_wstrb", m_if.wstrb, 32'hF);
        chk("t2_mem_wdata", m_if.wdata, 32'h12345678);
        m_if.addr_ok = 1'b1;
        #1;
        chk("t2_data_addr_ok", d_if.addr_ok, 32'd1);
        chk("t2_inst_addr_ok", i_if.addr_ok, 32'd0);
        @(negedge clk);
        d_if.req = 1'b0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h0badf00d;
        #1;
        chk("t2_data_data_ok", d_if.data_ok, 32'd1);
        chk("t2_inst_data_ok", i_if.data_ok, 32'd0);
        @(negedge clk);
        m_if.data_ok = 1'b0;
        #1;
        chk("t2_gap_mem_req", m_if.req, 32'd0);
        @(negedge clk);
        #1;
        chk("t2_inst_mem_req",  m_if.req,  32'd1);
        chk("t2_inst_mem_addr", m_if.addr, 32'h1c000004);
        chk("t2_inst_mem_wr",   m_if.wr,   32'd0);
        m_if.addr_ok = 1'b1;
        #1;
        chk("t2_inst_addr_ok", i_if.addr_ok, 32'd1);
        @(negedge clk);
        i_if.req = 1'b0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1;
        #1;
        chk("t2_inst_data_ok2", i_if.data_ok, 32'd1);
        @(negedge clk);
        clr();

        // ---------------- slave stall ----------------
        aok_cnt = 0; dok_cnt = 0; iok_cnt = 0;
        @(negedge clk);
        d_if.req = 1'b1; d_if.wr = 1'b1; d_if.size = 2'd1; d_if.wstrb = 4'b0011;
        d_if.addr = 32'h1c030008; d_if.wdata = 32'ha5a5c3c3;
        #1;
        aok_cnt += int'(d_if.addr_ok);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("t3_stall_mem_req",   m_if.req,   32'd1);
            chk("t3_stall_mem_addr",  m_if.addr,  32'h1c030008);
            chk("t3_stall_mem_wdata", m_if.wdata, 32'ha5a5c3c3);
            chk("t3_stall_mem_wstrb", m_if.wstrb, 32'h3);
            chk("t3_stall_mem_size",  m_if.size,  32'd1);
            aok_cnt += int'(d_if.addr_ok);
            iok_cnt += int'(i_if.addr_ok) + int'(i_if.data_ok);
        end
        @(negedge clk);
        m_if.addr_ok = 1'b1;
        #1;
        chk("t3_accept_mem_req", m_if.req, 32'd1);
        aok_cnt += int'(d_if.addr_ok);
        @(negedge clk);
        d_if.req = 1'b0; m_if.addr_ok = 1'b0;
        for (int k = 0; k < 9; k++) begin
            m_if.data_ok = (k == 6);
            #1;
            aok_cnt += int'(d_if.addr_ok);
            dok_cnt += int'(d_if.data_ok);
            iok_cnt += int'(i_if.addr_ok) + int'(i_if.data_ok);
            if (k == 6) chk("t3_data_ok_7th", d_if.data_ok, 32'd1);
            @(negedge clk);
        end
        m_if.data_ok = 1'b0;
        chk("t3_addr_ok_pulses", aok_cnt, 32'd1);
        chk("t3_data_ok_pulses", dok_cnt, 32'd1);
        chk("t3_inst_handshakes", iok_cnt, 32'd0);

        // ---------------- reset mid-transaction, spurious slave signals ----------------
        d_if.req = 1'b1; d_if.wr = 1'b0; d_if.addr = 32'h1c020000;
        @(negedge clk);
        m_if.addr_ok = 1'b1;
        #1;
        chk("t4_data_addr_ok", d_if.addr_ok, 32'd1);
        @(negedge clk);
        d_if.req = 1'b0; m_if.addr_ok = 1'b0;
        reset = 1'b1; m_if.data_ok = 1'b1; m_if.rdata = 32'hcafef00d;
        #1;
        chk("t4_rst_data_data_ok", d_if.data_ok, 32'd0);
        chk("t4_rst_inst_data_ok", i_if.data_ok, 32'd0);
        chk("t4_rst_data_rdata",   d_if.rdata,   32'd0);
        chk("t4_rst_mem_req",      m_if.req,     32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t4_stray_data_data_ok", d_if.data_ok, 32'd0);
        chk("t4_stray_inst_data_ok", i_if.data_ok, 32'd0);
        chk("t4_stray_mem_req",      m_if.req,     32'd0);
        @(negedge clk);
        m_if.data_ok = 1'b0;
        i_if.req = 1'b1; i_if.addr = 32'h1c000100;
        #1;
        chk("t4_idle_mem_req", m_if.req, 32'd0);
        @(negedge clk);
        #1;
        chk("t4_post_mem_req",  m_if.req,  32'd1);
        chk("t4_post_mem_addr", m_if.addr, 32'h1c000100);
        m_if.addr_ok = 1'b1;
        #1;
        chk("t4_post_inst_addr_ok", i_if.addr_ok, 32'd1);
        @(negedge clk);
        i_if.req = 1'b0; m_if.addr_ok = 1'b1;
        #1;
        chk("t5_resp_inst_addr_ok", i_if.addr_ok, 32'd0);
        chk("t5_resp_data_addr_ok", d_if.addr_ok, 32'd0);
        chk("t5_resp_mem_req",      m_if.req,     32'd0);
        @(negedge clk);
        m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h11112222;
        #1;
        chk("t5_resp_inst_data_ok", i_if.data_ok, 32'd1);
        chk("t5_resp_inst_rdata",   i_if.rdata,   32'h11112222);
        @(negedge clk);
        #1;
        chk("t5_idle_inst_data_ok", i_if.data_ok, 32'd0);
        chk("t5_idle_data_data_ok", d_if.data_ok, 32'd0);
        @(negedge clk);
        clr();
        #1;
        chk("t5_idle_mem_req", m_if.req, 32'd0);

        // ---------------- starvation bound ----------------
        phase = 0; owner = 0; streak = 0;
        p_start[0] = 100; p_start[1] = 100; p_aok = 100; p_dok = 100;
        glog.delete();
        for (int c = 0; c < 40; c++) model_cycle("starve");
        chk("starve_grant_count_ge10", (glog.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < glog.size(); k++) begin
            chk($sformatf("starve_grant%0d_owner", k), glog[k], ((k % 5) == 4) ? 32'd0 : 32'd1);
        end

        // ---------------- random traffic ----------------
        p_start[0] = 30; p_start[1] = 40; p_aok = 50; p_dok = 40;
        for (int c = 0; c < 1500; c++) model_cycle("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Two-master, one-slave arbiter for the sram-like (req/addr_ok/data_ok) memory interface. It sits between the CPU core's instruction-fetch port (master 0) and load/store port (master 1) and a single shared memory port feeding the AXI bridge. It serialises transactions, one outstanding at a time. The data port has priority, bounded by an anti-starvation limit that guarantees instruction fetch still makes progress.

Parameters:
MAX_DATA_STREAK, 4, max consecutive data grants while an inst request is pending; range 1..15.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
inst_req  in  1  master0 request; held until inst_addr_ok
inst_wr  in  1  master0 write flag
inst_size  in  2  master0 size (0=byte, 1=half, 2=word)
inst_wstrb  in  4  master0 byte strobes
inst_addr  in  32  master0 address
inst_wdata  in  32  master0 write data
inst_addr_ok  out  1  master0 request accepted
inst_data_ok  out  1  master0 response valid
inst_rdata  out  32  master0 read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  master1 request fields, same meaning as master0
data_addr_ok  out  1  master1 request accepted
data_data_ok  out  1  master1 response valid
data_rdata  out  32  master1 read data
mem_req  out  1  slave request
mem_wr  out  1  slave write flag
mem_size  out  2  slave size
mem_wstrb  out  4  slave byte strobes
mem_addr  out  32  slave address
mem_wdata  out  32  slave write data
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response valid
mem_rdata  in  32  slave read data

Behaviour:
- The FSM has three states: IDLE, REQ and RESP. An owner register `gnt` marks the granted master (0=inst, 1=data). A streak counter `streak` has ceil(log2(MAX_DATA_STREAK+1)) bits.
- Reset (sync, `reset`=1 at a clk edge):
  - state=IDLE, gnt=0, streak=0.
  - All outputs are 0, regardless of any transaction in flight.
  - Any slave response to a transaction cut off by reset is ignored, because the arbiter is in IDLE.
- IDLE:
  - If data_req=1 and inst_req=1: grant inst when streak==MAX_DATA_STREAK, otherwise grant data. Then go to REQ.
  - If only one request is high, grant that master and go to REQ.
  - If neither request is high, stay in IDLE.
  - mem_req=0 in IDLE. Arbitration takes 1 cycle, so mem_req rises the cycle after the master's req is first seen.
- Streak update on a grant:
  - Data granted while inst_req=1: streak+1, saturating at MAX_DATA_STREAK.
  - Data granted while inst_req=0: streak=0.
  - Inst granted: streak=0.
- REQ:
  - mem_req=1. mem_wr/size/wstrb/addr/wdata are a combinational mux of the granted master's fields; the master must hold them stable.
  - The granted master's addr_ok equals mem_addr_ok. The other master's addr_ok is 0.
  - On mem_addr_ok=1, go to RESP.
- RESP:
  - mem_req=0.
  - The granted master's data_ok equals mem_data_ok. The other master's data_ok is 0.
  - On mem_data_ok=1, go to IDLE.
  - Back-to-back: the next mem_req appears no earlier than 2 cycles after data_ok (IDLE arbitration + REQ).
- inst_rdata and data_rdata are both driven from mem_rdata. They are only meaningful when the corresponding data_ok is high.
- mem_data_ok outside RESP is ignored. mem_addr_ok outside REQ is ignored.
- Writes follow the same flow; data_ok marks write completion.
- A master that drops req before addr_ok is a protocol violation. The arbiter stays in REQ; mem_req keeps asserting with the dropped master's current inputs.
- addr_ok and data_ok are never asserted to both masters in the same cycle. At most one transaction is outstanding.

Test Plan:
- Single inst read: inst_req=1, addr=0x1c000000; slave addr_ok on the 1st REQ cycle, data_ok 2 cycles later with rdata=0x02800c0c -> mem_req high in cycle 1, inst_addr_ok in cycle 1, inst_data_ok with inst_rdata=0x02800c0c in cycle 3; data_* outputs stay 0.
- Simultaneous requests: inst_req=data_req=1; data is a store, addr=0x1c010004, wstrb=0xF, wdata=0x12345678 -> data is granted first and mem_wr=1 carries those values; inst is granted next, with its mem_req 2 cycles after data_data_ok.
- Starvation with MAX_DATA_STREAK=4: inst_req held and data_req continuously high -> 4 data grants, then 1 inst grant, then the streak restarts.
- Slave stall: mem_addr_ok held low 5 cycles, then data_ok delayed 7 cycles -> mem_req and its fields stable through the stall, addr_ok pulses exactly once, data_ok exactly once to the owner.
- Reset mid-transaction: reset=1 while in RESP, then a stray mem_data_ok=1 after reset -> all outputs 0, neither master sees data_ok, FSM in IDLE.
- Spurious slave signals: mem_data_ok=1 in IDLE and mem_addr_ok=1 in RESP -> no master handshake outputs, no state change.
